// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronise, debounce and edge-detect active-low push-buttons,
// serialising accepted presses into one-hot single-cycle strobes for the lock FSM.
module key_input_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PULSE_GAP       = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                dropped
);
  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;
  localparam logic [19:0] DEB = 20'(DEBOUNCE_CYCLES);
  localparam logic [3:0]  GAP = 4'(PULSE_GAP);

  logic [NUM_KEYS-1:0] meta_q, meta_d, sync_q, sync_d, sync_k;
  logic [1:0]          st_q  [NUM_KEYS];
  logic [1:0]          st_d  [NUM_KEYS];
  logic [19:0]         cnt_q [NUM_KEYS];
  logic [19:0]         cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] held_q, held_d, pend_q, pend_d, pulse_q, pulse_d;
  logic [NUM_KEYS-1:0] accept, cand, grant;
  logic [3:0]          gap_q, gap_d;
  logic                drop_q, drop_d;

  // Synchroniser flops hold the raw (active-low) level; idle after reset is "released".
  assign sync_k = ~sync_q;

  always_comb begin
    meta_d = key_n_in;
    sync_d = meta_q;
    held_d = held_q;
    accept = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        RELEASED:
          if (sync_k[i]) begin
            st_d[i]  = PRESS_WAIT;
            cnt_d[i] = 20'd1;
          end
        PRESS_WAIT:
          if (!sync_k[i]) begin
            st_d[i]  = RELEASED;
            cnt_d[i] = '0;
          end else if (cnt_q[i] + 20'd1 == DEB) begin
            st_d[i]   = PRESSED;
            cnt_d[i]  = '0;
            held_d[i] = 1'b1;
            accept[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 20'd1;
          end
        PRESSED:
          if (!sync_k[i]) begin
            st_d[i]  = RELEASE_WAIT;
            cnt_d[i] = 20'd1;
          end
        RELEASE_WAIT:
          if (sync_k[i]) begin
            st_d[i]  = PRESSED;
            cnt_d[i] = '0;
          end else if (cnt_q[i] + 20'd1 == DEB) begin
            st_d[i]   = RELEASED;
            cnt_d[i]  = '0;
            held_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + 20'd1;
          end
      endcase
    end
    // A press accepted this cycle is eligible immediately, so the strobe aligns with key_held.
    cand    = pend_q | accept;
    grant   = (gap_q == 4'd0) ? (cand & (~cand + NUM_KEYS'(1))) : '0;
    pend_d  = (cand & ~grant) | (accept & pend_q);
    gap_d   = (gap_q != 4'd0) ? gap_q - 4'd1 : ((|grant) ? GAP : 4'd0);
    pulse_d = grant;
    drop_d  = |(accept & pend_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q  <= '1;
      sync_q  <= '1;
      held_q  <= '0;
      pend_q  <= '0;
      pulse_q <= '0;
      gap_q   <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]  <= RELEASED;
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      held_q  <= held_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
      drop_q  <= drop_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key_pulse = pulse_q;
  assign key_held  = held_q;
  assign dropped   = drop_q;
endmodule

// File: tb/tb_key_input_conditioner.sv
// tb_key_input_conditioner: directed and random stimulus against a run-length/arbiter model,
// driving two instances (pulse gap 1 and 3) from the same buttons.
module tb_key_input_conditioner;
  localparam int DEB = 4;

  logic       clock, reset;
  logic [3:0] key_n_in;
  logic [3:0] p1, h1, p3, h3;
  logic       d1, d3;
  int         n_chk, n_fail;

  logic [3:0] m_d1, m_d2, m_held;
  int         m_run   [4];
  logic [3:0] m_pend  [2];
  logic [3:0] m_pulse [2];
  logic       m_drop  [2];
  int         m_gap   [2];

  key_input_conditioner #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(DEB), .PULSE_GAP(1)) dut1 (
    .clock(clock), .reset(reset), .key_n_in(key_n_in),
    .key_pulse(p1), .key_held(h1), .dropped(d1));

  key_input_conditioner #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(DEB), .PULSE_GAP(3)) dut3 (
    .clock(clock), .reset(reset), .key_n_in(key_n_in),
    .key_pulse(p3), .key_held(h3), .dropped(d3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = '1;
    m_d2 = '1;
    m_held = '0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
    for (int j = 0; j < 2; j++) begin
      m_pend[j] = '0;
      m_pulse[j] = '0;
      m_drop[j] = 1'b0;
      m_gap[j] = 0;
    end
  endtask

  // A key's debounced level flips once the synchronised level has disagreed with it
  // for DEB consecutive edges; presses queue and leave lowest-index first.
  task automatic model_step();
    logic [3:0] sync, acc, cand;
    int sel;
    sync = ~m_d2;
    m_d2 = m_d1;
    m_d1 = key_n_in;
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      if (sync[k] != m_held[k]) m_run[k]++; else m_run[k] = 0;
      if (m_run[k] == DEB) begin
        m_held[k] = sync[k];
        m_run[k] = 0;
        acc[k] = sync[k];
      end
    end
    for (int j = 0; j < 2; j++) begin
      cand = m_pend[j] | acc;
      m_drop[j] = |(acc & m_pend[j]);
      m_pulse[j] = '0;
      sel = -1;
      if (m_gap[j] == 0)
        for (int k = 3; k >= 0; k--) if (cand[k]) sel = k;
      if (sel >= 0) begin
        m_pulse[j][sel] = 1'b1;
        m_gap[j] = (j == 0) ? 1 : 3;
        if (!(m_pend[j][sel] && acc[sel])) cand[sel] = 1'b0;
      end else if (m_gap[j] > 0) begin
        m_gap[j]--;
      end
      m_pend[j] = cand;
    end
  endtask

  task automatic check_all();
    chk("held_g1", h1, m_held);
    chk("held_g3", h3, m_held);
    chk("pulse_g1", p1, m_pulse[0]);
    chk("pulse_g3", p3, m_pulse[1]);
    chk("drop_g1", {3'b0, d1}, {3'b0, m_drop[0]});
    chk("drop_g3", {3'b0, d3}, {3'b0, m_drop[1]});
    chk("onehot_g1", {3'b0, $countones(p1) <= 1}, 4'b0001);
    chk("onehot_g3", {3'b0, $countones(p3) <= 1}, 4'b0001);
  endtask

  task automatic tick(input logic [3:0] v);
    key_n_in = v;
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_pulse_g1", p1, 4'b0000);
    chk("rst_held_g1", h1, 4'b0000);
    chk("rst_pulse_g3", p3, 4'b0000);
    chk("rst_held_g3", h3, 4'b0000);
    chk("rst_drop", {2'b0, d1, d3}, 4'b0000);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int rise, fall, npulse, pedge, len;
    logic [3:0] v;
    n_chk = 0;
    n_fail = 0;
    key_n_in = '1;
    reset = 1'b0;
    model_reset();
    #2;
    apply_reset();

    // Clean press of key 0, then release
    rise = -1;
    npulse = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(4'b1110);
      if (rise < 0 && h1[0]) rise = i;
      if (p1 != 0) npulse++;
    end
    chk_int("t1_rise_edge", rise, 6);
    fall = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(4'b1111);
      if (fall < 0 && !h1[0]) fall = i;
      if (p1 != 0) npulse++;
    end
    chk_int("t1_fall_edge", fall, 6);
    chk_int("t1_pulse_count", npulse, 1);

    // Bounce on key 1
    for (int i = 0; i < 12; i++) tick((i % 4) < 2 ? 4'b1101 : 4'b1111);
    repeat (10) tick(4'b1111);

    // Simultaneous press of keys 1 and 3; also keys 0 and 2 for the gap-3 instance
    repeat (15) tick(4'b0101);
    repeat (10) tick(4'b1111);
    repeat (15) tick(4'b1010);
    repeat (10) tick(4'b1111);

    // Reset while key 3 is debouncing and key 0 is pending
    tick(4'b1101);
    tick(4'b1100);
    tick(4'b1100);
    repeat (4) tick(4'b0100);
    key_n_in = 4'b1111;
    apply_reset();
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick(4'b1111);
      if (p1 != 0 || p3 != 0) npulse++;
    end
    chk_int("t5_no_pulse_after_reset", npulse, 0);

    // Key 2 held through reset
    repeat (10) tick(4'b1011);
    apply_reset();
    npulse = 0;
    pedge = -1;
    for (int i = 1; i <= 15; i++) begin
      tick(4'b1011);
      if (p1 == 4'b0100) begin
        npulse++;
        if (pedge < 0) pedge = i;
      end
    end
    chk_int("t6_pulse_edge", pedge, 6);
    chk_int("t6_pulse_count", npulse, 1);
    repeat (10) tick(4'b1111);

    // Random button activity with occasional resets
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) apply_reset();
      v = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 10);
      repeat (len) tick(v);
    end
    repeat (20) tick(4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
